// File: rtl/mem_arbiter.sv
// Two-requester (IF / MEM) arbiter for a single valid/ready memory port; one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration; otherwise MEM has fixed priority over IF.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_resp_valid,
    output logic [DATA_W-1:0]     if_resp_data,
    input  logic                  mem_req_valid,
    input  logic                  mem_req_wen,
    input  logic [ADDR_W-1:0]     mem_req_addr,
    input  logic [DATA_W-1:0]     mem_req_wdata,
    input  logic [DATA_W/8-1:0]   mem_req_wstrb,
    output logic                  mem_req_ready,
    output logic                  mem_resp_valid,
    output logic [DATA_W-1:0]     mem_resp_data,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_req_wen,
    output logic [ADDR_W-1:0]     bus_req_addr,
    output logic [DATA_W-1:0]     bus_req_wdata,
    output logic [DATA_W/8-1:0]   bus_req_wstrb,
    input  logic                  bus_resp_valid,
    input  logic [DATA_W-1:0]     bus_resp_data,
    output logic                  busy
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q;
    logic   pick_mem;
    logic   accept;
    logic   resp_fire;

`ifdef ARB_RR_EN
    // 0 = IF preferred, 1 = MEM preferred; only consulted when both request.
    logic   rr_ptr_q;

    always_comb begin
        pick_mem = mem_req_valid && (!if_req_valid || rr_ptr_q);
    end
`else
    always_comb begin
        pick_mem = mem_req_valid;
    end
`endif

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        resp_fire     = 1'b0;
        if_req_ready  = 1'b0;
        mem_req_ready = 1'b0;
        bus_req_valid = 1'b0;
        busy          = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // Reset wins over a same-cycle accept so a requester never sees a dropped handshake.
                if (!rst && (if_req_valid || mem_req_valid)) begin
                    accept        = 1'b1;
                    if_req_ready  = !pick_mem;
                    mem_req_ready = pick_mem;
                    state_d       = REQ;
                end
            end
            REQ: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus_resp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_q        <= 1'b0;
            bus_req_wen    <= 1'b0;
            bus_req_addr   <= '0;
            bus_req_wdata  <= '0;
            bus_req_wstrb  <= '0;
            if_resp_valid  <= 1'b0;
            if_resp_data   <= '0;
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= '0;
`ifdef ARB_RR_EN
            rr_ptr_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            if_resp_valid  <= 1'b0;
            mem_resp_valid <= 1'b0;
            if (accept) begin
                grant_q       <= pick_mem;
                bus_req_wen   <= pick_mem && mem_req_wen;
                bus_req_addr  <= pick_mem ? mem_req_addr : if_req_addr;
                bus_req_wdata <= pick_mem ? mem_req_wdata : '0;
                bus_req_wstrb <= pick_mem ? mem_req_wstrb : STRB_W'(0);
`ifdef ARB_RR_EN
                rr_ptr_q      <= !pick_mem;
`endif
            end
            if (resp_fire) begin
                if (grant_q) begin
                    mem_resp_valid <= 1'b1;
                    // Writes return an acknowledge with zero data.
                    mem_resp_data  <= bus_req_wen ? '0 : bus_resp_data;
                end else begin
                    if_resp_valid  <= 1'b1;
                    if_resp_data   <= bus_resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model, directed scenarios, random traffic.
// Works with or without ARB_RR_EN defined.
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_resp_valid;
    logic [DW-1:0] if_resp_data;
    logic          mem_req_valid;
    logic          mem_req_wen;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic [SW-1:0] mem_req_wstrb;
    logic          mem_req_ready;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          bus_req_valid;
    logic          bus_req_ready;
    logic          bus_req_wen;
    logic [AW-1:0] bus_req_addr;
    logic [DW-1:0] bus_req_wdata;
    logic [SW-1:0] bus_req_wstrb;
    logic          bus_resp_valid;
    logic [DW-1:0] bus_resp_data;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wen(bus_req_wen),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data), .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_proto = 0;
    int n_dut_pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, described by what was captured and how far it got.
    bit            m_busy, m_sent, m_grant, m_wen, m_ptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    bit            m_pulse, m_pulse_mem;
    logic [DW-1:0] m_pulse_data;
    bit            dut_log[$];
    bit            win_mem, exp_if_rdy, exp_mem_rdy;

    function automatic bit pick_mem_model(input bit iv, input bit mv, input bit ptr);
        if (iv && mv) begin
`ifdef ARB_RR_EN
            return ptr;
`else
            return 1'b1;
`endif
        end
        return mv;
    endfunction

    always @(negedge clk) begin
        win_mem     = pick_mem_model(if_req_valid, mem_req_valid, m_ptr);
        exp_if_rdy  = !rst && !m_busy && if_req_valid && !win_mem;
        exp_mem_rdy = !rst && !m_busy && mem_req_valid && win_mem;
        chk("if_req_ready", 64'(if_req_ready), 64'(exp_if_rdy));
        chk("mem_req_ready", 64'(mem_req_ready), 64'(exp_mem_rdy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("bus_req_valid", 64'(bus_req_valid), 64'(m_busy && !m_sent));
        if (m_busy && !m_sent) begin
            chk("bus_req_wen", 64'(bus_req_wen), 64'(m_wen));
            chk("bus_req_addr", bus_req_addr, m_addr);
            chk("bus_req_wdata", bus_req_wdata, m_wdata);
            chk("bus_req_wstrb", 64'(bus_req_wstrb), 64'(m_wstrb));
        end
        chk("if_resp_valid", 64'(if_resp_valid), 64'(m_pulse && !m_pulse_mem));
        chk("mem_resp_valid", 64'(mem_resp_valid), 64'(m_pulse && m_pulse_mem));
        if (m_pulse && m_pulse_mem) chk("mem_resp_data", mem_resp_data, m_pulse_data);
        if (m_pulse && !m_pulse_mem) chk("if_resp_data", if_resp_data, m_pulse_data);
        if (if_req_ready) dut_log.push_back(1'b0);
        if (mem_req_ready) dut_log.push_back(1'b1);
        if (if_resp_valid || mem_resp_valid) n_dut_pulses++;
        if (!rst && bus_resp_valid && !(m_busy && m_sent)) begin
            n_proto++;
            $display("protocol error: bus_resp_valid outside RESP, ignored (t=%0t)", $time);
        end
        // Advance the model to what the next rising edge produces.
        m_pulse = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_sent = 1'b0;
            m_ptr  = 1'b0;
        end else if (!m_busy) begin
            if (if_req_valid || mem_req_valid) begin
                m_busy  = 1'b1;
                m_sent  = 1'b0;
                m_grant = win_mem;
                m_wen   = win_mem && mem_req_wen;
                m_addr  = win_mem ? mem_req_addr : if_req_addr;
                m_wdata = win_mem ? mem_req_wdata : '0;
                m_wstrb = win_mem ? mem_req_wstrb : '0;
                m_ptr   = !win_mem;
            end
        end else if (!m_sent) begin
            if (bus_req_ready) m_sent = 1'b1;
        end else if (bus_resp_valid) begin
            m_pulse      = 1'b1;
            m_pulse_mem  = m_grant;
            m_pulse_data = (m_grant && m_wen) ? '0 : bus_resp_data;
            m_busy       = 1'b0;
        end
    end

    // Downstream memory responder, active while dn_en is set.
    bit            dn_en = 1'b0;
    bit            dn_rand = 1'b0;
    int            dn_ready_pct = 100;
    int            dn_dly_max = 0;
    logic [DW-1:0] dn_data = '0;

    initial begin
        bit dn_acc, dn_rst, dn_pend;
        int dn_cnt;
        dn_pend = 1'b0;
        dn_cnt  = 0;
        forever begin
            @(negedge clk);
            dn_acc = bus_req_valid && bus_req_ready;
            dn_rst = rst;
            @(posedge clk);
            #1;
            if (dn_en) begin
                bus_resp_valid = 1'b0;
                if (dn_rst) begin
                    dn_pend = 1'b0;
                end else begin
                    if (dn_acc) begin
                        dn_pend = 1'b1;
                        dn_cnt  = (dn_dly_max == 0) ? 0 : $urandom_range(0, dn_dly_max);
                    end
                    if (dn_pend) begin
                        if (dn_cnt == 0) begin
                            bus_resp_valid = 1'b1;
                            bus_resp_data  = dn_rand ? {$urandom, $urandom} : dn_data;
                            dn_pend        = 1'b0;
                        end else begin
                            dn_cnt--;
                        end
                    end
                end
                bus_req_ready = ($urandom_range(0, 99) < dn_ready_pct);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input bit is_mem, input int budget, input string name);
        bit acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            acc = is_mem ? (mem_req_valid && mem_req_ready) : (if_req_valid && if_req_ready);
            next_cycle();
        end
        if (is_mem) mem_req_valid = 1'b0;
        else if_req_valid = 1'b0;
        chk(name, 64'(acc), 64'd1);
    endtask

    task automatic wait_pulse(input bit is_mem, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = is_mem ? mem_resp_valid : if_resp_valid;
            next_cycle();
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    bit exp_ord [3];
    bit ia, ma;

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        mem_req_valid = 1'b0; mem_req_wen = 1'b0; mem_req_addr = '0;
        mem_req_wdata = '0; mem_req_wstrb = '0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0;
        dn_en = 1'b1; dn_ready_pct = 100; dn_dly_max = 0; dn_rand = 1'b0;
        dn_data = 64'h0000_0013_0000_0093;
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bus_req_valid", 64'(bus_req_valid), 64'd0);
        chk("rst_bus_req_addr", bus_req_addr, 64'd0);
        chk("rst_bus_req_wdata", bus_req_wdata, 64'd0);
        chk("rst_bus_req_wstrb_wen", {55'd0, bus_req_wen, bus_req_wstrb}, 64'd0);
        chk("rst_resp_valid", {62'd0, if_resp_valid, mem_resp_valid}, 64'd0);
        chk("rst_resp_data", if_resp_data | mem_resp_data, 64'd0);
        next_cycle();

        // IF read with an immediately responding memory.
        if_req_addr = 64'h8000_0000; if_req_valid = 1'b1;
        @(negedge clk);
        chk("t1_if_ready_c0", 64'(if_req_ready), 64'd1);
        next_cycle(); if_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_bus_addr_c1", bus_req_addr, 64'h8000_0000);
        chk("t1_bus_valid_c1", 64'(bus_req_valid), 64'd1);
        next_cycle(); next_cycle();
        @(negedge clk);
        chk("t1_if_resp_valid_c3", 64'(if_resp_valid), 64'd1);
        chk("t1_if_resp_data_c3", if_resp_data, 64'h0000_0013_0000_0093);
        chk("t1_mem_resp_valid_c3", 64'(mem_resp_valid), 64'd0);
        chk("t1_busy_c3", 64'(busy), 64'd0);
        next_cycle();

        // MEM write: exact bus fields and a zero-data acknowledge.
        mem_req_wen = 1'b1; mem_req_addr = 64'h8000_1000;
        mem_req_wdata = 64'hDEAD_BEEF; mem_req_wstrb = 8'h0F; mem_req_valid = 1'b1;
        @(negedge clk);
        chk("t2_mem_ready_c0", 64'(mem_req_ready), 64'd1);
        next_cycle(); mem_req_valid = 1'b0;
        @(negedge clk);
        chk("t2_bus_fields", {bus_req_wen, bus_req_wstrb, bus_req_wdata[31:0]}, {23'd0, 1'b1, 8'h0F, 32'hDEAD_BEEF});
        chk("t2_bus_addr", bus_req_addr, 64'h8000_1000);
        next_cycle(); next_cycle();
        @(negedge clk);
        chk("t2_mem_resp_valid_c3", 64'(mem_resp_valid), 64'd1);
        chk("t2_mem_resp_data_c3", mem_resp_data, 64'd0);
        chk("t2_if_resp_valid_c3", 64'(if_resp_valid), 64'd0);
        next_cycle(); next_cycle();

        // Simultaneous requests held for three back-to-back grants, starting from a fresh pointer.
        rst = 1'b1; next_cycle(); rst = 1'b0;
        dut_log.delete();
        mem_req_wen = 1'b0; mem_req_addr = 64'h8000_2000;
        if_req_addr = 64'h8000_0004;
        if_req_valid = 1'b1; mem_req_valid = 1'b1;
        repeat (7) next_cycle();
        if_req_valid = 1'b0; mem_req_valid = 1'b0;
`ifdef ARB_RR_EN
        exp_ord = '{1'b0, 1'b1, 1'b0};
`else
        exp_ord = '{1'b1, 1'b1, 1'b1};
`endif
        chk("t3_grant_count", 64'(dut_log.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_grant_%0d", i), 64'((dut_log.size() > i) ? dut_log[i] : 1'bx), 64'(exp_ord[i]));
        end
        repeat (4) next_cycle();

        // Downstream stall of 10 cycles in REQ, with IF waiting behind it.
        dn_en = 1'b0; next_cycle();
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        mem_req_wen = 1'b0; mem_req_addr = 64'h8000_3000; mem_req_valid = 1'b1;
        @(negedge clk);
        chk("t4_mem_ready_c0", 64'(mem_req_ready), 64'd1);
        next_cycle(); mem_req_valid = 1'b0;
        if_req_addr = 64'h8000_0008; if_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                chk("t4_bus_valid_stall", 64'(bus_req_valid), 64'd1);
                chk("t4_bus_addr_stall", bus_req_addr, 64'h8000_3000);
                chk("t4_readies_stall", {62'd0, if_req_ready, mem_req_ready}, 64'd0);
            end
            next_cycle();
        end
        bus_req_ready = 1'b1;
        next_cycle();
        bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'h1122_3344_5566_7788;
        next_cycle();
        bus_resp_valid = 1'b0;
        @(negedge clk);
        chk("t4_mem_resp_valid", 64'(mem_resp_valid), 64'd1);
        chk("t4_mem_resp_data", mem_resp_data, 64'h1122_3344_5566_7788);
        chk("t4_if_accept_on_pulse", 64'(if_req_valid && if_req_ready), 64'd1);
        next_cycle();
        if_req_valid = 1'b0; dn_en = 1'b1; bus_req_ready = 1'b1;
        wait_pulse(1'b0, 20, "t4_if_resp_after_stall");
        repeat (2) next_cycle();

        // Reset while waiting for the response, then a late bus response.
        dn_en = 1'b0; next_cycle();
        bus_req_ready = 1'b1; bus_resp_valid = 1'b0;
        if_req_addr = 64'h8000_0010; if_req_valid = 1'b1;
        @(negedge clk);
        chk("t5_if_ready_c0", 64'(if_req_ready), 64'd1);
        next_cycle(); if_req_valid = 1'b0;
        next_cycle(); rst = 1'b1;
        @(negedge clk);
        chk("t5_busy_in_resp", 64'(busy), 64'd1);
        next_cycle(); rst = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'hAAAA_5555;
        @(negedge clk);
        chk("t5_busy_after_rst", 64'(busy), 64'd0);
        chk("t5_bus_valid_after_rst", 64'(bus_req_valid), 64'd0);
        next_cycle(); bus_resp_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_pulse", {62'd0, if_resp_valid, mem_resp_valid}, 64'd0);
        next_cycle();
        dn_en = 1'b1;
        if_req_addr = 64'h8000_0014; if_req_valid = 1'b1;
        wait_accept(1'b0, 5, "t5_fresh_accept");
        wait_pulse(1'b0, 10, "t5_fresh_resp");
        repeat (2) next_cycle();

        // Stray response while idle.
        dn_en = 1'b0; next_cycle();
        bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'h5A5A;
        next_cycle(); bus_resp_valid = 1'b0;
        @(negedge clk);
        chk("t6_no_pulse", {62'd0, if_resp_valid, mem_resp_valid}, 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("proto_errors_flagged", 64'(n_proto), 64'd2);
        next_cycle();

        // Random traffic with random downstream stalls, latencies and occasional resets.
        dn_en = 1'b1; dn_rand = 1'b1; dn_ready_pct = 70; dn_dly_max = 3;
        n_dut_pulses = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ia = if_req_valid && if_req_ready;
            ma = mem_req_valid && mem_req_ready;
            next_cycle();
            rst = ($urandom_range(0, 149) == 0);
            if (ia || !if_req_valid) begin
                if_req_valid = $urandom_range(0, 1);
                if_req_addr  = {$urandom, $urandom};
            end
            if (ma || !mem_req_valid) begin
                mem_req_valid = $urandom_range(0, 1);
                mem_req_wen   = $urandom_range(0, 1);
                mem_req_addr  = {$urandom, $urandom};
                mem_req_wdata = {$urandom, $urandom};
                mem_req_wstrb = SW'($urandom);
            end
        end
        rst = 1'b0; if_req_valid = 1'b0; mem_req_valid = 1'b0;
        repeat (10) next_cycle();
        chk("rand_activity", 64'(n_dut_pulses > 200), 64'd1);
        chk("rand_no_proto_errors", 64'(n_proto), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
